// File: rtl/string_hw_pkg.sv
// Shared definitions for the String_HW core and the blocks around it:
// command field widths and the scheduler state encoding.
package string_hw_pkg;

    localparam int INDEX_W  = 4;
    localparam int LENGTH_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/string_hw_scheduler_if.sv
// Requester/core-facing signal bundle of the String_HW scheduler.
//
// Handshakes: a command transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; the requester holds req_valid[i] and its
// command stable until then. A completion transfers in a cycle where
// resp_valid[i] and resp_ready[i] are both high; resp_valid/resp_timeout/
// grant stay stable until then.
interface string_hw_scheduler_if #(
    parameter int NUM_REQ = 2
) ();
    import string_hw_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*INDEX_W-1:0]  req_index;
    logic [NUM_REQ*LENGTH_W-1:0] req_length;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          resp_valid;
    logic                        resp_timeout;
    logic [NUM_REQ-1:0]          resp_ready;
    logic [NUM_REQ-1:0]          grant;
    logic                        core_go;
    logic [INDEX_W-1:0]          core_index;
    logic [LENGTH_W-1:0]         core_length;
    logic                        core_done;
    logic                        busy;
    sched_state_t                state_dbg;

    // Requesters plus the core side (core_done) drive this view.
    modport master (
        output req_valid, req_index, req_length, resp_ready, core_done,
        input  req_ready, resp_valid, resp_timeout, grant,
               core_go, core_index, core_length, busy, state_dbg
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_index, req_length, resp_ready, core_done,
        output req_ready, resp_valid, resp_timeout, grant,
               core_go, core_index, core_length, busy, state_dbg
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr,
// wrapping around. Output is one-hot, or zero when nothing is requested.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    // Walk the requesters starting at ptr and keep only the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/string_hw_scheduler.sv
// Round-robin owner of the shared String_HW core: accepts one command,
// runs the core until done or timeout, then holds the grant until the
// owner acknowledges the completion.
module string_hw_scheduler
    import string_hw_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  clk,
    input logic                  reset,
    string_hw_scheduler_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t        state;
    sched_state_t        state_next;
    logic [PTR_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_REQ-1:0]  grant_q;
    logic [INDEX_W-1:0]  index_q;
    logic [LENGTH_W-1:0] length_q;
    logic                timeout_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [PTR_W-1:0]    win_idx;
    logic                accept;
    logic                ack;
    logic [NUM_REQ-1:0]  req_ready;
    logic [NUM_REQ-1:0]  resp_valid;
    logic                core_go;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    // Binary index of the arbitration winner, used to pick its command.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) win_idx = PTR_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state and handshake outputs. Acceptance is blocked while the
    // core still reports done and while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        core_go    = 1'b0;
        accept     = 1'b0;
        ack        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!reset && !bus.core_done && (|arb_grant)) begin
                    accept     = 1'b1;
                    req_ready  = arb_grant;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                core_go = 1'b1;
                if (bus.core_done || (cnt == CNT_LAST)) state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = grant_q;
                if (|(bus.resp_ready & grant_q)) begin
                    ack        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command registers, owner, pointer and run-length counter. Done
    // takes priority over the timeout when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            cnt       <= '0;
            grant_q   <= '0;
            index_q   <= '0;
            length_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                index_q   <= bus.req_index[int'(win_idx)*INDEX_W +: INDEX_W];
                length_q  <= bus.req_length[int'(win_idx)*LENGTH_W +: LENGTH_W];
                grant_q   <= arb_grant;
                rr_ptr    <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                cnt       <= '0;
                timeout_q <= 1'b0;
            end else if (state == ST_BUSY) begin
                cnt <= cnt + 1'b1;
                if (!bus.core_done && (cnt == CNT_LAST)) timeout_q <= 1'b1;
            end
            if (ack) grant_q <= '0;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_timeout = (state == ST_RESP) && timeout_q;
    assign bus.grant        = grant_q;
    assign bus.core_go      = core_go;
    assign bus.core_index   = index_q;
    assign bus.core_length  = length_q;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_string_hw_scheduler.sv
// Bench for string_hw_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all outputs compared every cycle
// against a transaction-level model of the scheduler.
module tb_string_hw_scheduler;
    import string_hw_pkg::*;

    localparam int N = 3;
    localparam int T = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    string_hw_scheduler_if #(.NUM_REQ(N)) bus ();

    string_hw_scheduler #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the core, whether it is answering, how
    // many run cycles have elapsed, and the rotating priority start.
    bit         m_on = 1'b0;
    int         m_owner = -1;
    bit         m_resp = 1'b0;
    int         m_run = 0;
    bit         m_to = 1'b0;
    int         m_ptr = 0;
    logic [3:0] m_idx = '0;
    logic [7:0] m_len = '0;

    function automatic int m_winner();
        if (reset || bus.core_done || m_owner >= 0) return -1;
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (reset) begin
            m_on = 1'b1; m_owner = -1; m_resp = 1'b0; m_run = 0;
            m_to = 1'b0; m_ptr = 0; m_idx = '0; m_len = '0;
        end else if (m_on) begin
            w = m_winner();
            if (w >= 0) begin
                m_owner = w; m_resp = 1'b0; m_run = 0; m_to = 1'b0;
                m_ptr = (w + 1) % N;
                m_idx = bus.req_index[w*4 +: 4];
                m_len = bus.req_length[w*8 +: 8];
            end else if (m_owner >= 0 && !m_resp) begin
                m_run++;
                if (bus.core_done) begin m_resp = 1'b1; m_to = 1'b0; end
                else if (m_run == T) begin m_resp = 1'b1; m_to = 1'b1; end
            end else if (m_owner >= 0 && m_resp && bus.resp_ready[m_owner]) begin
                m_owner = -1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Snapshots of the previous cycle, used only to steer stimulus.
    logic [N-1:0] snap_ready = '0;
    logic         snap_go    = 1'b0;

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_grant, e_rv;
        int w;
        if (m_on) begin
            e_ready = '0;
            w = m_winner();
            if (w >= 0) e_ready[w] = 1'b1;
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
            e_rv = m_resp ? e_grant : '0;
            check("model req_ready",    32'(bus.req_ready),    32'(e_ready));
            check("model grant",        32'(bus.grant),        32'(e_grant));
            check("model resp_valid",   32'(bus.resp_valid),   32'(e_rv));
            check("model resp_timeout", 32'(bus.resp_timeout), 32'(m_owner >= 0 && m_resp && m_to));
            check("model core_go",      32'(bus.core_go),      32'(m_owner >= 0 && !m_resp));
            check("model busy",         32'(bus.busy),         32'(m_owner >= 0));
            check("model core_index",   32'(bus.core_index),   32'(m_idx));
            check("model core_length",  32'(bus.core_length),  32'(m_len));
        end
        snap_ready = bus.req_ready;
        snap_go    = bus.core_go;
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, " grant"},   32'(bus.grant),        32'd0);
        check({tag, " go"},      32'(bus.core_go),      32'd0);
        check({tag, " busy"},    32'(bus.busy),         32'd0);
        check({tag, " ready"},   32'(bus.req_ready),    32'd0);
        check({tag, " rv"},      32'(bus.resp_valid),   32'd0);
        check({tag, " to"},      32'(bus.resp_timeout), 32'd0);
        check({tag, " index"},   32'(bus.core_index),   32'd0);
        check({tag, " length"},  32'(bus.core_length),  32'd0);
    endtask

    // One complete run with the core answering immediately; reports the
    // accepted requester, or -1 if none was accepted within the budget.
    task automatic run_one(output int who);
        who = -1;
        for (int c = 0; c < 20 && who < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) who = i;
            if (who < 0) cyc();
        end
        if (who < 0) begin
            check("run accept wait expired", 32'd0, 32'd1);
            return;
        end
        cyc();
        bus.core_done = 1'b1;
        cyc();
        bus.core_done  = 1'b0;
        bus.resp_ready = N'(1) << who;
        cyc();
        bus.resp_ready = '0;
    endtask

    initial begin
        int who;
        bus.req_valid  = '0;
        bus.req_index  = '0;
        bus.req_length = '0;
        bus.resp_ready = '0;
        bus.core_done  = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check_reset_outputs("reset");
        cyc();

        // Single request: index 3, length 12, done 5 cycles after go.
        bus.req_valid  = 3'b001;
        bus.req_index  = 12'h003;
        bus.req_length = 24'h00000c;
        @(negedge clk);
        check("single ready", 32'(bus.req_ready), 32'b001);
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        check("single go",     32'(bus.core_go),     32'd1);
        check("single grant",  32'(bus.grant),       32'b001);
        check("single index",  32'(bus.core_index),  32'd3);
        check("single length", 32'(bus.core_length), 32'd12);
        check("single ready1", 32'(bus.req_ready),   32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 5) bus.core_done = 1'b1;
            if (k == 6) bus.core_done = 1'b0;
            @(negedge clk);
            if (k < 6) check("single rv early", 32'(bus.resp_valid), 32'd0);
        end
        check("single rv",  32'(bus.resp_valid),   32'b001);
        check("single to",  32'(bus.resp_timeout), 32'd0);
        check("single go0", 32'(bus.core_go),      32'd0);
        cyc();
        bus.resp_ready = 3'b001;
        cyc();
        bus.resp_ready = '0;
        @(negedge clk);
        check("single grant after ack", 32'(bus.grant), 32'd0);
        check("single busy after ack",  32'(bus.busy),  32'd0);

        // Contention: req0 and req1 held valid, grants alternate from 0.
        do_reset();
        bus.req_valid  = 3'b011;
        bus.req_index  = 12'h0a5;
        bus.req_length = 24'h003377;
        for (int r = 0; r < 4; r++) begin
            run_one(who);
            check("contention owner", 32'(who), 32'(r % 2));
        end
        bus.req_valid = '0;

        // Timeout: done never raised.
        do_reset();
        bus.req_valid = 3'b001;
        @(negedge clk);
        check("timeout ready", 32'(bus.req_ready), 32'b001);
        cyc();
        bus.req_valid = '0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (k < 16) begin
                check("timeout rv early", 32'(bus.resp_valid), 32'd0);
                check("timeout go held",  32'(bus.core_go),    32'd1);
            end
        end
        check("timeout rv",  32'(bus.resp_valid),   32'b001);
        check("timeout to",  32'(bus.resp_timeout), 32'd1);
        check("timeout go0", 32'(bus.core_go),      32'd0);
        cyc();
        bus.resp_ready = 3'b001;
        cyc();
        bus.resp_ready = '0;

        // Done arrives in the same cycle the run would time out.
        bus.req_valid = 3'b001;
        @(negedge clk);
        check("tie ready", 32'(bus.req_ready), 32'b001);
        cyc();
        bus.req_valid = '0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) cyc();
            if (k == 15) bus.core_done = 1'b1;
            if (k == 16) bus.core_done = 1'b0;
            @(negedge clk);
        end
        check("tie rv", 32'(bus.resp_valid),   32'b001);
        check("tie to", 32'(bus.resp_timeout), 32'd0);
        cyc();
        bus.resp_ready = 3'b001;
        cyc();
        bus.resp_ready = '0;

        // Reset three cycles into a run; the pointer returns to 0.
        bus.req_valid = 3'b001;
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_reset_outputs("midbusy reset");
        cyc();
        bus.req_valid = 3'b011;
        @(negedge clk);
        check("post reset priority", 32'(bus.req_ready), 32'b001);
        cyc();
        bus.req_valid = '0;

        // Stuck done while idle, then a long-held and misdirected ack.
        do_reset();
        bus.core_done = 1'b1;
        bus.req_valid = 3'b001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stuck done ready", 32'(bus.req_ready), 32'd0);
            check("stuck done busy",  32'(bus.busy),      32'd0);
            cyc();
        end
        bus.core_done = 1'b0;
        @(negedge clk);
        check("unstuck ready", 32'(bus.req_ready), 32'b001);
        cyc();
        bus.req_valid = '0;
        bus.core_done = 1'b1;
        cyc();
        bus.core_done = 1'b0;
        for (int k = 0; k < 23; k++) begin
            if (k >= 20) bus.resp_ready = 3'b110;
            @(negedge clk);
            check("held rv",    32'(bus.resp_valid), 32'b001);
            check("held grant", 32'(bus.grant),      32'b001);
            cyc();
        end
        bus.resp_ready = 3'b001;
        cyc();
        bus.resp_ready = '0;
        @(negedge clk);
        check("held released", 32'(bus.grant), 32'd0);
        cyc();

        // Randomized traffic, core latency and acks, with rare resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int dly;
            if (c == 0) dly = 0;
            for (int r = 0; r < N; r++) begin
                if (bus.req_valid[r] && snap_ready[r]) begin
                    bus.req_valid[r] = 1'b0;
                end else if (!bus.req_valid[r] && $urandom_range(0, 3) == 0) begin
                    bus.req_valid[r]        = 1'b1;
                    bus.req_index[r*4 +: 4] = 4'($urandom_range(0, 15));
                    bus.req_length[r*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
            if (snap_go) begin
                if (dly == 0) bus.core_done = 1'b1;
                else          dly--;
            end else begin
                bus.core_done = ($urandom_range(0, 15) == 0);
                dly = $urandom_range(0, 19);
            end
            for (int r = 0; r < N; r++) bus.resp_ready[r] = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset = 1'b0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
